// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - shared types, defaults and write-priority helper for reg_bank_mp
package regbank_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_W   = 64;
    localparam int DEF_AW  = 5;
    localparam int DEF_NRD = 2;
    localparam int DEF_NWR = 2;

    localparam int MAX_PORTS  = 8;
    localparam int PORT_IDX_W = 3;

    // Highest-indexed asserted hit wins when several ports target one register.
    function automatic logic [PORT_IDX_W-1:0] wr_winner(input logic [MAX_PORTS-1:0] hits);
        wr_winner = '0;
        for (int j = 0; j < MAX_PORTS; j++) begin
            if (hits[j]) begin
                wr_winner = PORT_IDX_W'(j);
            end
        end
    endfunction

endpackage

// File: rtl/regbank_scoreboard.sv
// rtl/regbank_scoreboard.sv - per-register busy bits, reserve over clear; REGBANK_BYPASS_EN taps post-update bits
module regbank_scoreboard
    import regbank_pkg::*;
#(
    parameter int AW  = DEF_AW,
    parameter int NRD = DEF_NRD,
    parameter int NWR = DEF_NWR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              upd_en,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_tap
);

    localparam int DEPTH = 1 << AW;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;

    // A reserve in the same cycle as a writeback wins: a new producer is outstanding.
    always_comb begin
        busy_nxt = busy;
        if (upd_en) begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j]) begin
                    busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
                end
            end
            if (rsv_en) begin
                busy_nxt[rsv_addr] = 1'b1;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
`ifdef REGBANK_BYPASS_EN
            rd_tap[i] = busy_nxt[rd_addr[i*AW +: AW]];
`else
            rd_tap[i] = busy[rd_addr[i*AW +: AW]];
`endif
        end
    end

endmodule

// File: rtl/reg_bank_mp.sv
// rtl/reg_bank_mp.sv - multi-port register bank with clear sequencer and busy scoreboard; REGBANK_BYPASS_EN selects write-before-read
module reg_bank_mp
    import regbank_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int AW  = DEF_AW,
    parameter int NRD = DEF_NRD,
    parameter int NWR = DEF_NWR
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_done,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*W-1:0]  rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NWR*W-1:0]  wr_data,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr
);

    localparam int DEPTH = 1 << AW;

    state_t          state;
    logic [AW-1:0]   clr_cnt;
    logic            run_en;
    logic [W-1:0]    mem [DEPTH];
    logic [NWR-1:0]  addr_hit [DEPTH];
    logic [W-1:0]    rd_word [NRD];
    logic [NRD-1:0]  sb_tap;

    assign run_en = (state == ST_RUN) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            clr_cnt   <= '0;
            init_done <= 1'b0;
        end else if (state == ST_INIT) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == AW'(DEPTH - 1)) begin
                state     <= ST_RUN;
                init_done <= 1'b1;
            end
        end
    end

    // Decoded write hits per register; register 0 never matches so its writes drop.
    always_comb begin
        for (int a = 0; a < DEPTH; a++) begin
            for (int j = 0; j < NWR; j++) begin
                addr_hit[a][j] = run_en && wr_en[j] && (a != 0) &&
                                 (wr_addr[j*AW +: AW] == AW'(a));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[clr_cnt] <= '0;
        end else begin
            for (int a = 1; a < DEPTH; a++) begin
                if (|addr_hit[a]) begin
                    mem[a] <= wr_data[int'(wr_winner(MAX_PORTS'(addr_hit[a])))*W +: W];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_word[i] = mem[rd_addr[i*AW +: AW]];
`ifdef REGBANK_BYPASS_EN
            if (|addr_hit[rd_addr[i*AW +: AW]]) begin
                rd_word[i] = wr_data[int'(wr_winner(MAX_PORTS'(addr_hit[rd_addr[i*AW +: AW]])))*W +: W];
            end
`endif
        end
    end

    regbank_scoreboard #(
        .AW  (AW),
        .NRD (NRD),
        .NWR (NWR)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .upd_en   (run_en),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rd_addr  (rd_addr),
        .rd_tap   (sb_tap)
    );

    always_ff @(posedge clk) begin
        for (int i = 0; i < NRD; i++) begin
            if (rst || state != ST_RUN || rd_addr[i*AW +: AW] == '0) begin
                rd_data[i*W +: W] <= '0;
                rd_busy[i]        <= 1'b0;
            end else begin
                rd_data[i*W +: W] <= rd_word[i];
                rd_busy[i]        <= sb_tap[i];
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_mp.sv
// tb/tb_reg_bank_mp.sv - randomized self-checking bench for reg_bank_mp against an array reference model
module tb_reg_bank_mp;

    logic         clk;
    logic         rst;
    logic         init_done;
    logic [9:0]   rd_addr;
    logic [127:0] rd_data;
    logic [1:0]   rd_busy;
    logic [1:0]   wr_en;
    logic [9:0]   wr_addr;
    logic [127:0] wr_data;
    logic         rsv_en;
    logic [4:0]   rsv_addr;

    int checks;
    int failures;

    logic [63:0] m_mem  [32];
    logic        m_busy [32];
    logic [63:0] n_mem  [32];
    logic        n_busy [32];

    reg_bank_mp dut (
        .clk       (clk),
        .rst       (rst),
        .init_done (init_done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int a = 0; a < 32; a++) begin
            m_mem[a]  = '0;
            m_busy[a] = 1'b0;
        end
    endtask

    // Ports applied in index order so a later port overwrites an earlier one; reserve last.
    task automatic model_next();
        n_mem  = m_mem;
        n_busy = m_busy;
        for (int j = 0; j < 2; j++) begin
            if (wr_en[j] && wr_addr[j*5 +: 5] != 5'd0) begin
                n_mem[wr_addr[j*5 +: 5]]  = wr_data[j*64 +: 64];
                n_busy[wr_addr[j*5 +: 5]] = 1'b0;
            end
        end
        if (rsv_en && rsv_addr != 5'd0) begin
            n_busy[rsv_addr] = 1'b1;
        end
    endtask

    task automatic step();
        logic [63:0] ed [2];
        logic        eb [2];
        logic [4:0]  a;
        model_next();
        for (int i = 0; i < 2; i++) begin
            a = rd_addr[i*5 +: 5];
`ifdef REGBANK_BYPASS_EN
            ed[i] = (a == 5'd0) ? 64'd0 : n_mem[a];
            eb[i] = (a == 5'd0) ? 1'b0 : n_busy[a];
`else
            ed[i] = (a == 5'd0) ? 64'd0 : m_mem[a];
            eb[i] = (a == 5'd0) ? 1'b0 : m_busy[a];
`endif
        end
        m_mem  = n_mem;
        m_busy = n_busy;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rd_data%0d", i), rd_data[i*64 +: 64], ed[i]);
            check($sformatf("rd_busy%0d", i), 64'(rd_busy[i]), 64'(eb[i]));
        end
    endtask

    task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [63:0] wd0,
                         input logic [4:0] wa1, input logic [63:0] wd1, input logic re,
                         input logic [4:0] ra, input logic [4:0] r0, input logic [4:0] r1);
        wr_en    = we;
        wr_addr  = {wa1, wa0};
        wr_data  = {wd1, wd0};
        rsv_en   = re;
        rsv_addr = ra;
        rd_addr  = {r1, r0};
        step();
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
        rd_addr  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rd_data", rd_data[63:0], 64'd0);
        check("rst_rd_busy", 64'(rd_busy), 64'd0);
        check("rst_init_done", 64'(init_done), 64'd0);

        rst = 1'b0;
        for (int c = 0; c < 32; c++) begin
            check("init_low", 64'(init_done), 64'd0);
            @(negedge clk);
        end
        check("init_high", 64'(init_done), 64'd1);
        model_clear();

        for (int a = 0; a < 32; a += 2) begin
            drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0, 5'(a), 5'(a + 1));
        end

        drive(2'b01, 5'd5, 64'hDEADBEEF_00000001, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd5);
        check("basic_r5", rd_data[127:64], 64'hDEADBEEF_00000001);

        drive(2'b11, 5'd7, 64'h11, 5'd7, 64'h22, 1'b0, 5'd0, 5'd0, 5'd0);
        drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd7, 5'd0);
        check("prio_r7", rd_data[63:0], 64'h22);
        drive(2'b01, 5'd0, 64'hFF, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        check("r0_zero", rd_data[63:0], 64'd0);

        drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b1, 5'd9, 5'd0, 5'd0);
        drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd9, 5'd9);
        check("rsv_busy", 64'(rd_busy[0]), 64'd1);
        drive(2'b10, 5'd0, 64'd0, 5'd9, 64'h1234, 1'b0, 5'd0, 5'd0, 5'd0);
        drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd9, 5'd0);
        check("wb_clear", 64'(rd_busy[0]), 64'd0);
        drive(2'b01, 5'd9, 64'h99, 5'd0, 64'd0, 1'b1, 5'd9, 5'd0, 5'd0);
        drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd9);
        check("rsv_wins", 64'(rd_busy[1]), 64'd1);
        check("rsv_wr_data", rd_data[127:64], 64'h99);

        drive(2'b01, 5'd3, 64'hAA, 5'd0, 64'd0, 1'b0, 5'd0, 5'd3, 5'd0);
`ifdef REGBANK_BYPASS_EN
        check("collide", rd_data[63:0], 64'hAA);
`else
        check("collide", rd_data[63:0], 64'h0);
`endif

        for (int c = 0; c < 400; c++) begin
            drive(2'($urandom), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                  5'($urandom_range(0, 7)), {$urandom, $urandom}, 1'($urandom),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        drive(2'b01, 5'd4, 64'h55, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd4, 5'd0);
        check("pre_rst_r4", rd_data[63:0], 64'h55);

        rst      = 1'b1;
        wr_en    = 2'b11;
        wr_addr  = {5'd4, 5'd4};
        wr_data  = {64'h77, 64'h66};
        rsv_en   = 1'b1;
        rsv_addr = 5'd4;
        rd_addr  = {5'd4, 5'd4};
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_init", 64'(init_done), 64'd0);
        rst = 1'b0;
        n   = 0;
        while (!init_done && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            check("init_rd", rd_data[63:0], 64'd0);
            n++;
        end
        check("mid_init_done", 64'(init_done), 64'd1);
        model_clear();
        drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd4, 5'd4);
        check("post_rst_r4", rd_data[63:0], 64'd0);
        check("post_rst_busy", 64'(rd_busy[1]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
